// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep sample holding register feeding a 32-slot stereo frame (same word on both channels).
// Outputs change on the clk edge where bclk falls; s_ready drops the cycle after an accept and samples offered while it is low are dropped (overrun).
module i2s_tx #(
    parameter int unsigned DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        frame_start,
    output logic        underrun,
    output logic        overrun
);

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  div_cnt_q;
    logic [4:0]  bit_cnt_q;
    logic [15:0] active_q;
    logic [15:0] hold_q;
    logic        hold_full_q;
    logic        stop_k0_q;
    logic        bclk_q;
    logic        lrclk_q;
    logic        sdata_q;
    logic        s_ready_q;
    logic        frame_start_q;
    logic        underrun_q;
    logic        overrun_q;

    logic        div_wrap;
    logic        fall;
    logic        k0;
    logic [4:0]  bit_cnt_d;
    logic [3:0]  bit_idx;
    logic        sdata_d;
    logic        lrclk_d;
    logic        accept;
    logic        load;
    logic        under;
    logic        hold_full_d;

    always_comb begin
        div_wrap    = (div_cnt_q == DIV_LAST);
        fall        = (state_q != IDLE) && div_wrap && bclk_q;
        bit_cnt_d   = bit_cnt_q + 5'd1;
        k0          = (bit_cnt_d == 5'd0);
        // Slot k carries bit (16 - k) mod 16: the LSB lands one slot late, in k=0 and k=16.
        bit_idx     = 4'd0 - bit_cnt_d[3:0];
        sdata_d     = active_q[bit_idx];
        lrclk_d     = bit_cnt_d[4];
        accept      = s_valid && s_ready_q;
        load        = fall && (state_q == RUN) && k0 && hold_full_q;
        under       = fall && (state_q == RUN) && k0 && !hold_full_q;
        hold_full_d = hold_full_q;
        if (accept) begin
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            div_cnt_q     <= 8'd0;
            bit_cnt_q     <= 5'd31;
            active_q      <= 16'd0;
            hold_q        <= 16'd0;
            hold_full_q   <= 1'b0;
            stop_k0_q     <= 1'b0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            s_ready_q     <= 1'b1;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            frame_start_q <= load;
            underrun_q    <= under;
            overrun_q     <= s_valid && !s_ready_q;
            if (accept) begin
                hold_q <= s_data;
            end
            hold_full_q <= hold_full_d;
            s_ready_q   <= !hold_full_d;

            case (state_q)
                IDLE: begin
                    div_cnt_q <= 8'd0;
                    bit_cnt_q <= 5'd31;
                    active_q  <= 16'd0;
                    bclk_q    <= 1'b0;
                    lrclk_q   <= 1'b0;
                    sdata_q   <= 1'b0;
                    stop_k0_q <= 1'b0;
                    if (en) begin
                        state_q <= RUN;
                    end
                end
                RUN, STOP: begin
                    if (div_wrap) begin
                        div_cnt_q <= 8'd0;
                        bclk_q    <= !bclk_q;
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                    if (fall) begin
                        // STOP ends one slot after its k=0 edge, once the last right LSB is out.
                        if ((state_q == STOP) && stop_k0_q) begin
                            state_q   <= IDLE;
                            div_cnt_q <= 8'd0;
                            bit_cnt_q <= 5'd31;
                            active_q  <= 16'd0;
                            lrclk_q   <= 1'b0;
                            sdata_q   <= 1'b0;
                            stop_k0_q <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_d;
                            lrclk_q   <= lrclk_d;
                            sdata_q   <= sdata_d;
                            if (load) begin
                                active_q <= hold_q;
                            end
                            if ((state_q == STOP) && k0) begin
                                stop_k0_q <= 1'b1;
                            end
                        end
                    end
                    if ((state_q == RUN) && !en) begin
                        state_q   <= STOP;
                        stop_k0_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_q;
    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a frame-arithmetic reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_i2s_tx;

    localparam int DIV = 4;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        en      = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data  = 16'd0;
    logic        s_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        frame_start;
    logic        underrun;
    logic        overrun;

    i2s_tx #(.DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the frame derived from the count of clk edges since entering run.
    int          m_mode = 0;   // 0 idle, 1 run, 2 stop
    int          m_n    = 0;
    int          m_k    = 0;
    bit          m_acc  = 1'b0;
    bit          m_full = 1'b0;
    bit          m_sdone = 1'b0;
    logic [15:0] m_active = 16'd0;
    logic [15:0] m_hold   = 16'd0;
    logic e_bclk = 1'b0, e_lr = 1'b0, e_sd = 1'b0, e_rdy = 1'b1;
    logic e_fs = 1'b0, e_ur = 1'b0, e_or = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_n = 0; m_full = 1'b0; m_sdone = 1'b0;
            m_active = 16'd0; m_hold = 16'd0;
            e_bclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0; e_rdy = 1'b1;
            e_fs = 1'b0; e_ur = 1'b0; e_or = 1'b0;
        end else begin
            e_fs  = 1'b0;
            e_ur  = 1'b0;
            m_acc = s_valid && !m_full;
            e_or  = s_valid && m_full;
            if (m_mode == 0) begin
                e_bclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0; m_active = 16'd0;
                if (en) begin
                    m_mode = 1;
                    m_n    = 0;
                end
            end else begin
                m_n++;
                e_bclk = ((m_n / DIV) % 2) != 0;
                if ((m_n % (2 * DIV)) == 0) begin
                    m_k = (m_n / (2 * DIV) - 1) % 32;
                    if (m_mode == 2 && m_sdone) begin
                        m_mode = 0; e_lr = 1'b0; e_sd = 1'b0; m_active = 16'd0;
                    end else begin
                        e_lr = (m_k >= 16);
                        e_sd = ((m_k % 16) == 0) ? m_active[0] : m_active[16 - (m_k % 16)];
                        if (m_k == 0) begin
                            if (m_mode == 1) begin
                                if (m_full) begin
                                    m_active = m_hold; m_full = 1'b0; e_fs = 1'b1;
                                end else begin
                                    e_ur = 1'b1;
                                end
                            end else begin
                                m_sdone = 1'b1;
                            end
                        end
                    end
                end
                if (m_mode == 1 && !en) begin
                    m_mode  = 2;
                    m_sdone = 1'b0;
                end
            end
            if (m_acc) begin
                m_hold = s_data;
                m_full = 1'b1;
            end
            e_rdy = !m_full;
        end
    end

    always @(negedge clk) begin
        check("bclk", bclk, e_bclk);
        check("lrclk", lrclk, e_lr);
        check("sdata", sdata, e_sd);
        check("s_ready", s_ready, e_rdy);
        check("frame_start", frame_start, e_fs);
        check("underrun", underrun, e_ur);
        check("overrun", overrun, e_or);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_fall(output int cnt);
        logic prev;
        bit   found;
        prev  = bclk;
        found = 1'b0;
        cnt   = 0;
        while (!found && cnt < 4 * DIV + 4) begin
            @(posedge clk);
            #2;
            cnt++;
            if (prev && !bclk) found = 1'b1;
            prev = bclk;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_fall: no bclk fall within %0d cycles at %0t", cnt, $time);
        end
    endtask

    task automatic get_word(output logic [15:0] w, output logic lr, output logic fs, output logic ur);
        int c;
        w = 16'd0;
        for (int i = 0; i < 16; i++) begin
            wait_fall(c);
            w = {w[14:0], sdata};
        end
        lr = lrclk;
        fs = frame_start;
        ur = underrun;
    endtask

    task automatic skip_falls(input int n);
        int c;
        for (int i = 0; i < n; i++) wait_fall(c);
    endtask

    initial begin
        int          c;
        logic [15:0] w;
        logic        lr, fs, ur;

        #1 rst = 1'b1;
        tick(1);
        check("reset_outs", {bclk, lrclk, sdata, frame_start, underrun, overrun}, 6'd0);
        check("reset_ready", s_ready, 1'b1);
        rst = 1'b0;
        tick(2);

        // Sample accepted while idle, then start.
        s_valid = 1'b1; s_data = 16'h8001;
        tick(1);
        s_valid = 1'b0;
        check("ready_after_push", s_ready, 1'b0);
        en = 1'b1;
        wait_fall(c);
        check("first_fall_latency", c - 1, 8);
        check("fs_first_k0", frame_start, 1'b1);
        check("sdata_first_k0", sdata, 1'b0);
        get_word(w, lr, fs, ur);
        check("left_word_f1", w, 16'h8001);
        check("lrclk_k16", lr, 1'b1);
        get_word(w, lr, fs, ur);
        check("right_word_f1", w, 16'h8001);
        check("underrun_k0_f2", ur, 1'b1);
        check("no_fs_k0_f2", fs, 1'b0);
        get_word(w, lr, fs, ur);
        check("left_word_repeat", w, 16'h8001);

        // Two pushes in one frame: the second is dropped.
        s_valid = 1'b1; s_data = 16'h1234;
        tick(1);
        check("ready_after_1234", s_ready, 1'b0);
        s_data = 16'h5678;
        tick(1);
        check("overrun_pulse", overrun, 1'b1);
        s_valid = 1'b0;
        tick(1);
        check("overrun_once", overrun, 1'b0);
        get_word(w, lr, fs, ur);
        check("right_word_f2", w, 16'h8001);
        check("fs_k0_f3", fs, 1'b1);
        get_word(w, lr, fs, ur);
        check("left_word_1234", w, 16'h1234);

        // Offer a sample in the load cycle with the holding register full.
        s_valid = 1'b1; s_data = 16'hAAAA;
        tick(1);
        s_valid = 1'b0;
        tick(2 * DIV * 16 - 2);
        s_valid = 1'b1; s_data = 16'hBBBB;
        tick(1);
        check("fs_load", frame_start, 1'b1);
        check("overrun_load", overrun, 1'b1);
        check("ready_after_load", s_ready, 1'b1);
        s_data = 16'hCCCD;
        tick(1);
        s_valid = 1'b0;
        check("accept_after_load", s_ready, 1'b0);
        check("no_overrun_after_load", overrun, 1'b0);
        get_word(w, lr, fs, ur);
        check("left_word_aaaa", w, 16'hAAAA);

        // Drop en at k=5 of the next frame.
        skip_falls(21);
        en = 1'b0;
        skip_falls(11);
        get_word(w, lr, fs, ur);
        check("right_word_stop", w, 16'hCCCD);
        check("stop_k0_sdata", sdata, 1'b1);
        check("stop_k0_no_fs", fs, 1'b0);
        check("stop_k0_no_ur", ur, 1'b0);
        wait_fall(c);
        check("idle_outs", {bclk, lrclk, sdata}, 3'd0);
        check("idle_ready", s_ready, 1'b1);
        tick(6 * DIV);
        check("idle_bclk_quiet", bclk, 1'b0);

        // Reset in the middle of a frame, then restart.
        en = 1'b1;
        wait_fall(c);
        skip_falls(20);
        rst = 1'b1;
        #1;
        check("midframe_reset", {bclk, lrclk, sdata, frame_start, underrun, overrun, s_ready}, 7'b0000001);
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_fall(c);
        check("restart_latency", c - 1, 8);
        check("restart_underrun", underrun, 1'b1);
        check("restart_no_fs", frame_start, 1'b0);
        check("restart_sdata", sdata, 1'b0);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter: DIV, default 4, clk cycles per BCLK half-period; legal range 2..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  run request; level-sensitive.
REQ-005 s_data  input  16  signed PCM sample from filter output.
REQ-006 s_valid  input  1  one-cycle sample strobe.
REQ-007 s_ready  output  1  holding register empty; registered.
REQ-008 bclk  output  1  serial bit clock.
REQ-009 lrclk  output  1  word select; 0 = left, 1 = right.
REQ-010 sdata  output  1  serial data, MSB first.
REQ-011 frame_start  output  1  one-cycle pulse: a new word was loaded.
REQ-012 underrun  output  1  one-cycle pulse: frame began with the holding register empty.
REQ-013 overrun  output  1  one-cycle pulse: sample dropped.

Function
REQ-014 States: IDLE, RUN, STOP; reset to IDLE.
REQ-015 Transitions: IDLE->RUN when en=1; RUN->STOP when en=0; STOP->IDLE per REQ-023; en changes in STOP are ignored.
REQ-016 In IDLE, hold bclk/lrclk/sdata=0, div_cnt=0, bit_cnt=31, and active word=0.
REQ-017 Divider, RUN/STOP: div_cnt counts 0..DIV-1; at DIV-1, toggle bclk and reset to 0.
REQ-018 Falling edge = cycle in which bclk toggles 1->0; the first falling edge occurs 2*DIV cycles after entering RUN; frame length is 64*DIV clk cycles.
REQ-019 Falling edge actions: advance bit_cnt (31 wraps to 0); set the new slot k; update lrclk and sdata in the same cycle; these signals are stable at bclk rising edge.
REQ-020 lrclk = 1 for k in 16..31, else 0.
REQ-021 sdata mapping: k=0 -> bit0 of the previous active word; k=16 -> bit0 of active; k in 1..15 and 17..31 -> active[16-(k mod 16)]; both channels carry the same word.
REQ-022 Frame load at falling edge with k=0, RUN only: sdata uses the old active word; if holding register full, active<=hold, hold emptied, frame_start pulses; else active unchanged (repeat), underrun pulses.
REQ-023 STOP: slots complete normally; at the k=0 edge, emit old bit0 with no load and no underrun; at the next falling edge, enter IDLE.
REQ-024 Accept s_data when s_valid=1 and s_ready=1; s_ready deasserts the next cycle.
REQ-025 s_valid=1 with s_ready=0: drop the sample, hold unchanged, overrun pulses next cycle.
REQ-026 Simultaneous accept and frame load: s_ready reflects the pre-load value, so a sample in the load cycle with s_ready=0 is an overrun; s_ready rises the cycle after the load.
REQ-027 Accepting samples is legal in IDLE; the held sample loads at the first k=0 of RUN.
REQ-028 All outputs registered; pulse outputs are high exactly one cycle.

Reset
REQ-029 Async rst: bclk=0, lrclk=0, sdata=0, s_ready=1, frame_start=0, underrun=0, overrun=0, state IDLE, hold empty, active=0.
REQ-030 rst mid-frame: outputs go low immediately; no further bits are emitted; restart requires en after release.

Verification
REQ-031 DIV=4, push 0x8001, then en=1 -> first falling edge at cycle 8; frame_start at k=0; sdata over k=1..16 = 1,0x14,1; lrclk rises at k=16; right slot identical.
REQ-032 Run two frames with no new sample -> underrun pulses at 2nd k=0; word repeated; frame_start absent.
REQ-033 Push 0x1234 then 0x5678 before the next k=0 -> 2nd sample dropped; overrun pulses once; 0x1234 transmitted.
REQ-034 s_valid in the k=0 load cycle with hold full -> overrun; s_ready=1 the next cycle; a sample one cycle later is accepted.
REQ-035 Drop en at k=5 -> frame completes; k=0 slot emits right LSB; IDLE at the next falling edge with all outputs 0.
REQ-036 Assert rst at k=20 -> all outputs 0 within the same cycle; s_ready=1; after release with en=1, timing matches REQ-031.
